// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared FSM state encoding and operation mode codes for the serial adder/subtractor
package add_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;
endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice: SLICE-bit combinational ripple of full add/subtract cells with chain in/out
module add_sub_slice
  import add_sub_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic             mode,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);
  logic [SLICE:0] c;
  logic [SLICE-1:0] p;
  // a borrow is the carry of ~a + b + borrow, so subtract reuses the majority cell on ~a
  assign p = (mode == MODE_ADD) ? a : ~a;
  assign c[0] = ci;
  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (p[i] & b[i]) | (p[i] & c[i]) | (b[i] & c[i]);
  end
  assign co = c[SLICE];
endmodule

// File: rtl/binary_add_sub_serial.sv
// binary_add_sub_serial: multi-cycle add/subtract processing one SLICE-bit slice per clock
module binary_add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b0,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int SL = (SLICE < 1) ? 1 : SLICE;
  localparam int N  = WIDTH / SL;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int M  = WIDTH - 1;
  if (SLICE < 1 || SLICE > WIDTH || WIDTH % SL != 0) begin : g_bad_cfg
    $error("binary_add_sub_serial: SLICE must divide WIDTH and lie in 1..WIDTH");
  end
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [BW-1:0] base;
  logic chain, mode_r, accept, last, co;
  logic [WIDTH-1:0] xr, yr, acc, res;
  logic [SLICE-1:0] s;
  assign accept = start && state != RUN;
  assign last = idx == IW'(N - 1);
  assign base = BW'(32'(idx) * 32'(SLICE));
  assign busy = state == RUN;
  assign done = state == DONE;
  add_sub_slice #(.SLICE(SLICE)) u_slice (
    .mode(mode_r),
    .a   (xr[base +: SLICE]),
    .b   (yr[base +: SLICE]),
    .ci  (chain),
    .s   (s),
    .co  (co)
  );
  always_comb begin
    res = acc;
    res[base +: SLICE] = s;
  end
  always_comb begin
    state_n = accept ? RUN : (state == RUN ? (last ? DONE : RUN) : IDLE);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      chain  <= 1'b0;
      mode_r <= MODE_SUB;
      xr     <= '0;
      yr     <= '0;
      acc    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      xr     <= x;
      yr     <= y;
      mode_r <= mode;
      chain  <= b0;
      idx    <= '0;
    end else if (state == RUN) begin
      acc   <= res;
      chain <= co;
      idx   <= idx + IW'(1);
      if (last) begin
        d     <= res;
        b_out <= co;
        ovf   <= (mode_r == MODE_ADD) ? (xr[M] == yr[M] && res[M] != xr[M])
                                      : (xr[M] != yr[M] && res[M] != xr[M]);
        zero  <= res == '0;
      end
    end
  end
endmodule

// File: tb/tb_binary_add_sub_serial.sv
// tb_binary_add_sub_serial: scoreboard bench over SLICE=8, 1 and 32 instances of the serial adder
module tb_binary_add_sub_serial;
  localparam int LAT [3] = '{5, 33, 2};
  typedef struct {logic [31:0] d; logic b, o, z; int c0;} exp_t;
  typedef struct {logic m; logic [31:0] a, bb; logic ci; logic [31:0] d; logic b, o, z;} vec_t;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, b0 = 1'b0;
  logic [2:0] st = '0;
  logic [31:0] x = '0, y = '0;
  logic [31:0] d_o [3];
  logic b_o [3], v_o [3], z_o [3], busy_o [3], done_o [3];
  exp_t q [3][$];
  int cyc = 0, n_run = 0, n_fail = 0;
  int ndone [3] = '{0, 0, 0};
  vec_t dv [8] = '{
    '{1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0},
    '{1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
    '{1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
    '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
    '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
    '{1'b0, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
    '{1'b0, 32'h0000_0003, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
    '{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0}
  };
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  binary_add_sub_serial #(.WIDTH(32), .SLICE(8)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .mode(mode), .x(x), .y(y), .b0(b0),
    .d(d_o[0]), .b_out(b_o[0]), .ovf(v_o[0]), .zero(z_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  binary_add_sub_serial #(.WIDTH(32), .SLICE(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .mode(mode), .x(x), .y(y), .b0(b0),
    .d(d_o[1]), .b_out(b_o[1]), .ovf(v_o[1]), .zero(z_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  binary_add_sub_serial #(.WIDTH(32), .SLICE(32)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .mode(mode), .x(x), .y(y), .b0(b0),
    .d(d_o[2]), .b_out(b_o[2]), .ovf(v_o[2]), .zero(z_o[2]), .busy(busy_o[2]), .done(done_o[2]));
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(logic m, logic [31:0] a, logic [31:0] bb, logic ci);
    logic [32:0] t;
    exp_t e;
    t = m ? {1'b0, a} + {1'b0, bb} + 33'(ci) : {1'b0, a} - {1'b0, bb} - 33'(ci);
    e.d = t[31:0];
    e.b = t[32];
    e.o = m ? (a[31] == bb[31] && e.d[31] != a[31]) : (a[31] != bb[31] && e.d[31] != a[31]);
    e.z = e.d == 32'h0;
    e.c0 = 0;
    return e;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      if (done_o[g]) begin
        ndone[g]++;
        if (q[g].size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL u%0d_unexpected_done: got done=1 expected no done at cycle %0d", g, cyc);
        end else begin
          exp_t e;
          e = q[g].pop_front();
          chk($sformatf("u%0d_d", g), d_o[g], e.d);
          chk($sformatf("u%0d_b_out", g), 32'(b_o[g]), 32'(e.b));
          chk($sformatf("u%0d_ovf", g), 32'(v_o[g]), 32'(e.o));
          chk($sformatf("u%0d_zero", g), 32'(z_o[g]), 32'(e.z));
          chk($sformatf("u%0d_latency", g), 32'(cyc - e.c0), 32'(LAT[g]));
        end
      end
    end
  end
  task automatic issue(logic [2:0] mk, logic m, logic [31:0] a, logic [31:0] bb, logic ci,
                       logic [31:0] ed, logic eb, logic eo, logic ez);
    exp_t e;
    e.d = ed; e.b = eb; e.o = eo; e.z = ez; e.c0 = cyc;
    mode = m; x = a; y = bb; b0 = ci; st = mk;
    for (int i = 0; i < 3; i++) if (mk[i]) q[i].push_back(e);
    @(negedge clk);
    st = '0;
  endtask
  task automatic wait_all();
    int k = 0;
    while (q[0].size() + q[1].size() + q[2].size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain_timeout: pending %0d/%0d/%0d expected none", q[0].size(), q[1].size(), q[2].size());
      q[0].delete(); q[1].delete(); q[2].delete();
    end
  endtask
  task automatic chk_zero(int g, string nm);
    chk($sformatf("%s_u%0d_d", nm, g), d_o[g], 32'h0);
    chk($sformatf("%s_u%0d_flags", nm, g),
        32'({b_o[g], v_o[g], z_o[g], busy_o[g], done_o[g]}), 32'h0);
  endtask
  initial begin
    int n0, k;
    exp_t e;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) chk_zero(g, "reset");
    rst = 1'b0;
    @(negedge clk);
    foreach (dv[i]) begin
      issue(3'b111, dv[i].m, dv[i].a, dv[i].bb, dv[i].ci, dv[i].d, dv[i].b, dv[i].o, dv[i].z);
      wait_all();
      repeat (2) @(negedge clk);
      for (int g = 0; g < 3; g++) chk($sformatf("held_u%0d_v%0d", g, i), d_o[g], dv[i].d);
    end
    n0 = ndone[0];
    issue(3'b001, 1'b0, 32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_in_run", 32'(busy_o[0]), 32'h1);
    st = 3'b001; x = 32'h0000_FFFF; y = 32'd7; mode = 1'b1; b0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    st = '0;
    wait_all();
    repeat (8) @(negedge clk);
    chk("ignore_single_done", 32'(ndone[0] - n0), 32'h1);
    chk("ignore_result_held", d_o[0], 32'd99);
    n0 = ndone[0];
    issue(3'b001, 1'b1, 32'd9, 32'd4, 1'b0, 32'd13, 1'b0, 1'b0, 1'b0);
    void'(q[0].pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero(0, "abort");
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(ndone[0] - n0), 32'h0);
    issue(3'b001, 1'b1, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (!done_o[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done_o[0]) begin
      n_run++;
      n_fail++;
      $display("FAIL b2b_done_timeout: got no done expected done within 20 cycles");
    end
    issue(3'b001, 1'b0, 32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);
    wait_all();
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, bb;
      logic ci;
      a = $urandom;
      bb = (i % 7 == 0) ? a : $urandom;
      ci = 1'($urandom_range(0, 1));
      e = model(1'(i % 2), a, bb, ci);
      issue(3'b111, 1'(i % 2), a, bb, ci, e.d, e.b, e.o, e.z);
      x = $urandom; y = $urandom; mode = ~mode; b0 = ~b0;
      wait_all();
    end
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
